// File: rtl/modulo_varredura_mux_pkg.sv
// Shared constants, FSM state encoding and channel-to-bit mapping for the
// modulo_varredura_mux scan controller.
package modulo_varredura_mux_pkg;

  localparam int unsigned SEL_W      = 2;
  localparam int unsigned N_CANAIS   = 4;
  localparam int unsigned DIV_PADRAO = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  // The mux routes sel=00 to e[3] ... sel=11 to e[0], so the sample lands in bit 3-sel.
  function automatic logic [SEL_W-1:0] bit_canal(input logic [SEL_W-1:0] sel);
    return SEL_W'(N_CANAIS - 1) - sel;
  endfunction

endpackage

// File: rtl/modulo_contador_janela.sv
// Per-channel window counter: counts 0..DIV-1 while enabled, flags the last
// cycle of the window with tc and reloads to 0 instead of overflowing.
module modulo_contador_janela #(
  parameter int unsigned DIV = 4,
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/modulo_varredura_mux.sv
// Scan controller for modulo_mux4_1: steps sel through all four channels and
// assembles the samples into amostra. Define VARREDURA_SYNC_EN to synchronize mux_out.
module modulo_varredura_mux
  import modulo_varredura_mux_pkg::*;
#(
  parameter int unsigned DIV = DIV_PADRAO
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                modo_continuo,
  input  logic                mux_out,
  output logic [SEL_W-1:0]    sel,
  output logic [N_CANAIS-1:0] amostra,
  output logic                valido,
  output logic                ocupado
);

  logic dado_amostra;

`ifdef VARREDURA_SYNC_EN
  if (DIV < 3 || DIV > 256) begin : g_div_invalido
    $error("modulo_varredura_mux: DIV must be 3..256 with the synchronizer enabled");
  end

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], mux_out};
    end
  end

  assign dado_amostra = sync_q[1];
`else
  if (DIV < 2 || DIV > 256) begin : g_div_invalido
    $error("modulo_varredura_mux: DIV must be 2..256");
  end

  assign dado_amostra = mux_out;
`endif

  logic [0:0]          estado_q, estado_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [N_CANAIS-1:0] shadow_q, shadow_d;
  logic [N_CANAIS-1:0] amostra_q, amostra_d;
  logic                valido_q, valido_d;
  logic                fim_janela;

  modulo_contador_janela #(
    .DIV (DIV)
  ) u_contador (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (estado_q == IDLE),
    .en    (estado_q == SCAN),
    .tc    (fim_janela)
  );

  always_comb begin
    estado_d  = estado_q;
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    amostra_d = amostra_q;
    valido_d  = 1'b0;
    case (estado_q)
      IDLE: begin
        if (start) begin
          estado_d = SCAN;
          sel_d    = '0;
        end
      end
      SCAN: begin
        if (fim_janela) begin
          shadow_d[bit_canal(sel_q)] = dado_amostra;
          sel_d                      = sel_q + SEL_W'(1);
          if (sel_q == SEL_W'(N_CANAIS - 1)) begin
            // Last channel goes straight to amostra; shadow bit 0 is not yet visible.
            amostra_d = {shadow_q[N_CANAIS-1:1], dado_amostra};
            valido_d  = 1'b1;
            sel_d     = '0;
            if (!modo_continuo) begin
              estado_d = IDLE;
            end
          end
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= IDLE;
      sel_q     <= '0;
      shadow_q  <= '0;
      amostra_q <= '0;
      valido_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      amostra_q <= amostra_d;
      valido_q  <= valido_d;
    end
  end

  assign sel     = sel_q;
  assign amostra = amostra_q;
  assign valido  = valido_q;
  assign ocupado = (estado_q == SCAN);

endmodule

// File: tb/tb_modulo_varredura_mux.sv
// Directed bench for modulo_varredura_mux with a behavioural 4:1 mux model
// (sel=00 -> e[3] ... sel=11 -> e[0]) in front of each instance.
module tb_modulo_varredura_mux;

`ifdef VARREDURA_SYNC_EN
  localparam int DMIN = 3;
`else
  localparam int DMIN = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DIV=4 instance
  logic       start4 = 1'b0, modo4 = 1'b0;
  logic [3:0] e4 = 4'h0;
  logic [1:0] sel4;
  logic [3:0] am4;
  logic       v4, oc4, m4;
  assign m4 = e4[2'd3 - sel4];

  modulo_varredura_mux #(.DIV(4)) dut4 (
    .clk (clk), .rst_n (rst_n), .start (start4), .modo_continuo (modo4),
    .mux_out (m4), .sel (sel4), .amostra (am4), .valido (v4), .ocupado (oc4)
  );

  // Minimum-DIV instance
  logic       start2 = 1'b0;
  logic [3:0] e2 = 4'h0;
  logic [1:0] sel2;
  logic [3:0] am2;
  logic       v2, oc2, m2;
  assign m2 = e2[2'd3 - sel2];

  modulo_varredura_mux #(.DIV(DMIN)) dut2 (
    .clk (clk), .rst_n (rst_n), .start (start2), .modo_continuo (1'b0),
    .mux_out (m2), .sel (sel2), .amostra (am2), .valido (v2), .ocupado (oc2)
  );

  // DIV=7 instance
  logic       start7 = 1'b0;
  logic [3:0] e7 = 4'h0;
  logic [1:0] sel7;
  logic [3:0] am7;
  logic       v7, oc7, m7;
  assign m7 = e7[2'd3 - sel7];

  modulo_varredura_mux #(.DIV(7)) dut7 (
    .clk (clk), .rst_n (rst_n), .start (start7), .modo_continuo (1'b0),
    .mux_out (m7), .sel (sel7), .amostra (am7), .valido (v7), .ocupado (oc7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int nv;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_sel4", 8'(sel4), 8'h0);
    chk("rst_am4", 8'(am4), 8'h0);
    chk("rst_v4", 8'(v4), 8'h0);
    chk("rst_oc4", 8'(oc4), 8'h0);
    chk("rst_oc2", 8'(oc2), 8'h0);
    chk("rst_oc7", 8'(oc7), 8'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_oc4", 8'(oc4), 8'h0);

    // Single scan, e=1011
    e4 = 4'b1011;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("t1_oc_e0", 8'(oc4), 8'h1);
    chk("t1_sel_e0", 8'(sel4), 8'h0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      chk("t1_sel", 8'(sel4), (n < 16) ? 8'(n / 4) : 8'h0);
      chk("t1_v", 8'(v4), (n == 16) ? 8'h1 : 8'h0);
      chk("t1_oc", 8'(oc4), (n < 16) ? 8'h1 : 8'h0);
      chk("t1_am", 8'(am4), (n >= 16) ? 8'hB : 8'h0);
    end

    // Continuous mode, input changed early in second scan, mode cleared mid-scan
    e4 = 4'b0101;
    modo4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      tick();
      chk("t2_v", 8'(v4), (n == 16 || n == 32) ? 8'h1 : 8'h0);
      chk("t2_oc", 8'(oc4), (n < 32) ? 8'h1 : 8'h0);
      chk("t2_am", 8'(am4), (n < 16) ? 8'hB : (n < 32) ? 8'h5 : 8'hE);
      if (n == 16) e4 = 4'b1110;
      if (n == 20) modo4 = 1'b0;
    end

    // start pulses during a scan are ignored, including at the final edge
    e4 = 4'b0011;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    nv = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (v4) nv++;
      chk("t3_am", 8'(am4), (n < 16) ? 8'hE : 8'h3);
      chk("t3_oc", 8'(oc4), (n < 16) ? 8'h1 : 8'h0);
      start4 = (n == 3 || n == 15);
    end
    chk("t3_nvalido", 8'(nv), 8'h1);
    chk("t3_sel_idle", 8'(sel4), 8'h0);

    // Reset asserted mid-scan
    e4 = 4'b1111;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int n = 1; n <= 9; n++) tick();
    chk("t4_sel_pre", 8'(sel4), 8'h2);
    rst_n = 1'b0;
    #1;
    chk("t4_sel", 8'(sel4), 8'h0);
    chk("t4_am", 8'(am4), 8'h0);
    chk("t4_v", 8'(v4), 8'h0);
    chk("t4_oc", 8'(oc4), 8'h0);
    tick();
    tick();
    rst_n = 1'b1;
    nv = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (v4) nv++;
    end
    chk("t4_nvalido", 8'(nv), 8'h0);
    chk("t4_am_after", 8'(am4), 8'h0);
    chk("t4_oc_after", 8'(oc4), 8'h0);

    // Minimum DIV, e=1000
    e2 = 4'b1000;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 1; n <= 4 * DMIN + 1; n++) begin
      tick();
      chk("t5_v", 8'(v2), (n == 4 * DMIN) ? 8'h1 : 8'h0);
      chk("t5_am", 8'(am2), (n >= 4 * DMIN) ? 8'h8 : 8'h0);
    end

    // DIV=7, e=0001
    e7 = 4'b0001;
    start7 = 1'b1;
    tick();
    start7 = 1'b0;
    for (int n = 1; n <= 29; n++) begin
      tick();
      chk("t6_v", 8'(v7), (n == 28) ? 8'h1 : 8'h0);
      chk("t6_am", 8'(am7), (n >= 28) ? 8'h1 : 8'h0);
      chk("t6_oc", 8'(oc7), (n < 28) ? 8'h1 : 8'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
